// File: rtl/stb_pkg.sv
// -----------------------------------------------------------------------------
// stb_pkg
// Shared definitions for the store-to-bus path (burst_store -> stb_axi_master):
// AXI burst/size/response encodings, legal burst-length codes, the write
// master state enum and small decode helpers.
// -----------------------------------------------------------------------------
package stb_pkg;

   // AXI burst type and transfer size used by every store burst
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_16B    = 3'b100;

   // AXI write response encodings
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Legal burst-length codes (beats minus one) shared with burst_store
   localparam logic [7:0] BURST_LEN_1     = 8'd0;
   localparam logic [7:0] BURST_LEN_2     = 8'd1;
   localparam logic [7:0] BURST_LEN_4     = 8'd3;
   localparam logic [7:0] BURST_LEN_8     = 8'd7;

   // Write master sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_AW    = 3'd1,
      ST_W     = 3'd2,
      ST_B     = 3'd3,
      ST_REARM = 3'd4
   } stb_state_e;

   // True for SLVERR and DECERR responses
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

   // True for the burst lengths burst_store is allowed to request
   function automatic logic burst_len_legal(input logic [7:0] len);
      return (len == BURST_LEN_1) || (len == BURST_LEN_2) ||
             (len == BURST_LEN_4) || (len == BURST_LEN_8);
   endfunction

endpackage

// File: rtl/stb_axi_master.sv
// -----------------------------------------------------------------------------
// stb_axi_master
// AXI4 write master directly downstream of burst_store. Takes one store
// request (address, one data word, burst length, strobes), issues it as a
// single INCR burst on AW/W/B, and pulses req_done when the response returns.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid             level request, held by upstream until req_done
//   req_addr/data/burst_len/wstrb   request payload (latched on accept)
//   req_done, req_err     one-cycle completion pulse and its error flag
//   busy                  high from accept until the completion pulse
//   aw*/w*/b*             AXI4 write address, write data and response channels
// -----------------------------------------------------------------------------
module stb_axi_master
   import stb_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 128,
   parameter int unsigned           STRB_WIDTH = 16,
   parameter int unsigned           ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0]   AXI_ID     = {ID_WIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [DATA_WIDTH-1:0]    req_data,
   input  logic [7:0]               req_burst_len,
   input  logic [STRB_WIDTH-1:0]    req_wstrb,
   output logic                     req_done,
   output logic                     req_err,
   output logic                     busy,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [ADDR_WIDTH-1:0]    awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic [ID_WIDTH-1:0]      awid,
   output logic                     wvalid,
   input  logic                     wready,
   output logic [DATA_WIDTH-1:0]    wdata,
   output logic [STRB_WIDTH-1:0]    wstrb,
   output logic                     wlast,
   input  logic                     bvalid,
   output logic                     bready,
   input  logic [1:0]               bresp,
   input  logic [ID_WIDTH-1:0]      bid
);

   stb_state_e                r_state;
   stb_state_e                w_state_nxt;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [7:0]                r_len;
   logic [STRB_WIDTH-1:0]     r_wstrb;
   logic [7:0]                r_beat;
   logic                      r_armed;
   logic                      r_done;
   logic                      r_err;

   logic                      w_accept;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_b_hs;
   logic                      w_last_beat;

   // Handshake and control decodes; all channel valids come straight from the
   // state register, so an asynchronous reset drops them immediately.
   assign w_accept    = (r_state == ST_IDLE) && req_valid && r_armed;
   assign w_last_beat = (r_beat == r_len);
   assign w_aw_hs     = awvalid && awready;
   assign w_w_hs      = wvalid && wready;
   assign w_b_hs      = bvalid && bready;

   assign awvalid  = (r_state == ST_AW);
   assign awaddr   = r_addr;
   assign awlen    = r_len;
   assign awsize   = AXI_SIZE_16B;
   assign awburst  = AXI_BURST_INCR;
   assign awid     = AXI_ID;
   assign wvalid   = (r_state == ST_W);
   assign wdata    = r_data;
   assign wstrb    = r_wstrb;
   assign wlast    = (r_state == ST_W) && w_last_beat;
   assign bready   = (r_state == ST_B);
   assign busy     = (r_state != ST_IDLE);
   assign req_done = r_done;
   assign req_err  = r_err;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: one pass IDLE -> AW -> W -> B -> REARM -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)                 w_state_nxt = ST_AW;
                   else                          w_state_nxt = ST_IDLE;
         ST_AW:    if (w_aw_hs)                  w_state_nxt = ST_W;
                   else                          w_state_nxt = ST_AW;
         ST_W:     if (w_w_hs && w_last_beat)    w_state_nxt = ST_B;
                   else                          w_state_nxt = ST_W;
         ST_B:     if (w_b_hs)                   w_state_nxt = ST_REARM;
                   else                          w_state_nxt = ST_B;
         ST_REARM:                               w_state_nxt = ST_IDLE;
         default:                                w_state_nxt = ST_IDLE;
      endcase
   end

   // Request payload capture; address is forced to a 16-byte boundary to match awsize
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= {ADDR_WIDTH{1'b0}};
         r_data  <= {DATA_WIDTH{1'b0}};
         r_len   <= 8'd0;
         r_wstrb <= {STRB_WIDTH{1'b0}};
      end else if (w_accept) begin
         r_addr  <= {req_addr[ADDR_WIDTH-1:4], 4'b0000};
         r_data  <= req_data;
         r_len   <= req_burst_len;
         r_wstrb <= req_wstrb;
      end
   end

   // Beat counter: cleared on accept, counts accepted W beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= 8'd0;
      end else if (w_accept) begin
         r_beat <= 8'd0;
      end else if (w_w_hs) begin
         r_beat <= r_beat + 8'd1;
      end
   end

   // Completion pulse; an ID mismatch is reported as an error too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_b_hs;
         r_err  <= w_b_hs && (resp_is_err(bresp) || (bid != AXI_ID));
      end
   end

   // Re-arm guard: a request level still high after completion must drop
   // before another request can be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b1;
      end else if (r_state == ST_REARM) begin
         r_armed <= 1'b0;
      end else if (!req_valid) begin
         r_armed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stb_axi_master.sv
module tb_stb_axi_master;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic [31:0]   req_addr;
   logic [127:0]  req_data;
   logic [7:0]    req_burst_len;
   logic [15:0]   req_wstrb;
   logic          req_done;
   logic          req_err;
   logic          busy;
   logic          awvalid;
   logic          awready;
   logic [31:0]   awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic [3:0]    awid;
   logic          wvalid;
   logic          wready;
   logic [127:0]  wdata;
   logic [15:0]   wstrb;
   logic          wlast;
   logic          bvalid;
   logic          bready;
   logic [1:0]    bresp;
   logic [3:0]    bid;

   always #5 clk = ~clk;

   stb_axi_master #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (128),
      .STRB_WIDTH (16),
      .ID_WIDTH   (4),
      .AXI_ID     (4'h0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_burst_len (req_burst_len),
      .req_wstrb     (req_wstrb),
      .req_done      (req_done),
      .req_err       (req_err),
      .busy          (busy),
      .awvalid       (awvalid),
      .awready       (awready),
      .awaddr        (awaddr),
      .awlen         (awlen),
      .awsize        (awsize),
      .awburst       (awburst),
      .awid          (awid),
      .wvalid        (wvalid),
      .wready        (wready),
      .wdata         (wdata),
      .wstrb         (wstrb),
      .wlast         (wlast),
      .bvalid        (bvalid),
      .bready        (bready),
      .bresp         (bresp),
      .bid           (bid)
   );

   typedef struct {
      logic [31:0]   addr;
      logic [7:0]    len;
      logic [127:0]  data;
      logic [15:0]   strb;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One complete transaction with the bench acting as AXI slave.
   task automatic run_txn(input logic [31:0] addr, input logic [7:0] len,
                          input logic [127:0] data, input logic [15:0] strb,
                          input logic [1:0] resp, input logic [3:0] rid,
                          input int aw_stall, input bit wtoggle, input bit stray_b,
                          input int hold, input int abort_beats);
      exp_t e;
      exp_t cur;
      int   cyc = 0;
      int   aw_wait = 0;
      int   beats = 0;
      bit   aw_done = 1'b0;
      bit   w_done = 1'b0;
      bit   fin = 1'b0;
      bit   abort_pend = 1'b0;
      bit   aborted = 1'b0;

      e.addr = addr & 32'hFFFF_FFF0;
      e.len  = len;
      e.data = data;
      e.strb = strb;
      e.err  = (resp == 2'b10) || (resp == 2'b11) || (rid != 4'h0);
      sb_q.push_back(e);

      req_valid = 1'b1; req_addr = addr; req_data = data;
      req_burst_len = len; req_wstrb = strb;
      bvalid = stray_b; bresp = resp; bid = rid;
      awready = 1'b0; wready = 1'b0;

      while (!fin && cyc < 100) begin
         @(negedge clk);
         cyc++;
         cur = sb_q[0];
         if (abort_pend) begin
            rst_n = 1'b0;
            #1;
            chk("rst_wvalid", 128'(wvalid), 128'(0));
            chk("rst_awvalid", 128'(awvalid), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_done", 128'(req_done), 128'(0));
            void'(sb_q.pop_front());
            fin = 1'b1;
            aborted = 1'b1;
         end else if (req_done) begin
            void'(sb_q.pop_front());
            chk("req_err", 128'(req_err), 128'(cur.err));
            chk("beat_count", 128'(beats), 128'(cur.len) + 128'(1));
            if (aw_stall == 0 && !wtoggle)
               chk("done_cycle", 128'(cyc), 128'(cur.len) + 128'(4));
            fin = 1'b1;
         end else begin
            chk("aw_w_excl", 128'(awvalid & wvalid), 128'(0));
            if (cyc == 1 && aw_stall == 0) chk("aw_latency", 128'(awvalid), 128'(1));
            if (!w_done) chk("bready_off", 128'(bready), 128'(0));
            if (awvalid) begin
               chk("aw_once", 128'(aw_done), 128'(0));
               chk("awaddr", 128'(awaddr), 128'(cur.addr));
               chk("awlen", 128'(awlen), 128'(cur.len));
               if (aw_wait == 0) begin
                  chk("awsize", 128'(awsize), 128'(3'b100));
                  chk("awburst", 128'(awburst), 128'(2'b01));
                  chk("awid", 128'(awid), 128'(4'h0));
               end
               awready = (aw_wait >= aw_stall);
               if (awready) aw_done = 1'b1;
               aw_wait++;
            end else begin
               awready = 1'b0;
            end
            if (wvalid) begin
               chk("w_after_aw", 128'(aw_done), 128'(1));
               chk("wdata", wdata, cur.data);
               chk("wstrb", 128'(wstrb), 128'(cur.strb));
               wready = wtoggle ? cyc[0] : 1'b1;
               if (wready) begin
                  beats++;
                  chk("wlast", 128'(wlast), 128'(beats == (int'(cur.len) + 1)));
                  if (wlast) w_done = 1'b1;
                  if (abort_beats != 0 && beats == abort_beats) abort_pend = 1'b1;
               end
            end else begin
               wready = 1'b0;
            end
            if (w_done) bvalid = 1'b1;
         end
      end

      if (!fin) begin
         chk("timeout", 128'(0), 128'(1));
         if (sb_q.size() != 0) void'(sb_q.pop_front());
      end

      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (aborted) begin
         req_valid = 1'b0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", 128'(req_done), 128'(0));
            chk("post_rst_busy", 128'(busy), 128'(0));
         end
      end else begin
         if (hold == 0) req_valid = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("no_reaccept", 128'(awvalid), 128'(0));
            chk("done_pulse", 128'(req_done), 128'(0));
         end
         req_valid = 1'b0;
         @(negedge clk);
         chk("done_pulse_end", 128'(req_done), 128'(0));
         chk("idle_awvalid", 128'(awvalid), 128'(0));
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_addr = 32'h0; req_data = 128'h0;
      req_burst_len = 8'h0; req_wstrb = 16'h0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_awvalid0", 128'(awvalid), 128'(0));
      chk("rst_wvalid0", 128'(wvalid), 128'(0));
      chk("rst_bready0", 128'(bready), 128'(0));
      chk("rst_done0", 128'(req_done), 128'(0));
      chk("rst_err0", 128'(req_err), 128'(0));
      chk("rst_busy0", 128'(busy), 128'(0));
      chk("rst_wlast0", 128'(wlast), 128'(0));
      chk("rst_awaddr0", 128'(awaddr), 128'(0));
      chk("rst_awsize0", 128'(awsize), 128'(3'b100));
      chk("rst_awburst0", 128'(awburst), 128'(2'b01));
      chk("rst_awid0", 128'(awid), 128'(4'h0));
      rst_n = 1'b1;
      @(negedge clk);

      // Single beat, all readies high
      run_txn(32'h0000_1000, 8'd0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C,
              16'hFFFF, 2'b00, 4'h0, 0, 1'b0, 1'b0, 0, 0);
      // 8-beat burst with wready toggling
      run_txn(32'h0000_2000, 8'd7, 128'hA5A5_5A5A_1111_2222_3333_4444_5555_6666,
              16'h0FF0, 2'b00, 4'h0, 0, 1'b1, 1'b0, 0, 0);
      // AW backpressure, unaligned address
      run_txn(32'h1234_5677, 8'd1, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10,
              16'h00FF, 2'b00, 4'h0, 5, 1'b0, 1'b0, 0, 0);
      // SLVERR, with a stray bvalid before state B
      run_txn(32'h0000_3000, 8'd3, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D,
              16'hF00F, 2'b10, 4'h0, 0, 1'b0, 1'b1, 0, 0);
      // DECERR
      run_txn(32'h0000_4010, 8'd1, 128'h1, 16'h0001, 2'b11, 4'h0, 0, 1'b0, 1'b0, 0, 0);
      // bid mismatch with OKAY response
      run_txn(32'h0000_5000, 8'd0, 128'h2, 16'h8000, 2'b00, 4'h5, 0, 1'b0, 1'b0, 0, 0);
      // Level-held request for 3 cycles after done, then a fresh request
      run_txn(32'h0000_6000, 8'd0, 128'h3, 16'hFFFF, 2'b00, 4'h0, 0, 1'b0, 1'b0, 3, 0);
      run_txn(32'h0000_6100, 8'd3, 128'h4, 16'hFFFF, 2'b01, 4'h0, 0, 1'b0, 1'b0, 0, 0);
      // Reset after the 2nd of 4 beats, then a normal transaction
      run_txn(32'h0000_7000, 8'd3, 128'h5, 16'hFFFF, 2'b00, 4'h0, 0, 1'b0, 1'b0, 0, 2);
      run_txn(32'h0000_7100, 8'd3, 128'h6, 16'h3C3C, 2'b00, 4'h0, 0, 1'b0, 1'b0, 0, 0);
      // Illegal burst length is issued unchanged
      run_txn(32'h0000_8000, 8'd5, 128'h7, 16'hFFFF, 2'b00, 4'h0, 0, 1'b0, 1'b0, 0, 0);

      chk("sb_empty", 128'(sb_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
